// File: rtl/xs_clk_pkg.sv
// Shared types and constants for the clock-enable / core-reset sequencer.
package xs_clk_pkg;

    typedef enum logic [1:0] {
        WAIT = 2'd0,
        HOLD = 2'd1,
        RUN  = 2'd2
    } seq_state_t;

    localparam int unsigned DIV_W = 5;

    // 6809 quadrature phase points within one 32-cycle divider period
    localparam logic [DIV_W-1:0] Q_RISE = DIV_W'(7);
    localparam logic [DIV_W-1:0] E_RISE = DIV_W'(15);
    localparam logic [DIV_W-1:0] Q_FALL = DIV_W'(23);
    localparam logic [DIV_W-1:0] E_FALL = DIV_W'(31);

    typedef struct packed {
        logic ce_12;
        logic ce_6;
        logic ce_3;
        logic ce_1p5;
        logic q_rise;
        logic e_rise;
        logic q_fall;
        logic e_fall;
    } ce_vec_t;

    // Map a divider value to the set of enables that belong to it
    function automatic ce_vec_t ce_decode(input logic [DIV_W-1:0] d);
        ce_vec_t r;
        r        = '0;
        r.ce_12  = &d[1:0];
        r.ce_6   = &d[2:0];
        r.ce_3   = &d[3:0];
        r.ce_1p5 = &d;
        r.q_rise = (d == Q_RISE);
        r.e_rise = (d == E_RISE);
        r.q_fall = (d == Q_FALL);
        r.e_fall = (d == E_FALL);
        return r;
    endfunction

endpackage

// File: rtl/xs_sync2.sv
// Generic two-flop synchronizer for asynchronous single-bit flags.
module xs_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic rst_val,
    input  logic d,
    output logic q
);

    logic meta;

    // Two-stage capture; both stages load rst_val while in reset
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= rst_val;
            q    <= rst_val;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/xs_clk_rst_seq.sv
// Core reset sequencer and clock-enable generator on the 48 MHz PLL clock.
// Holds core_rst until lock has been stable for LOCK_HOLD cycles with no
// ROM download, then emits divided enables from a free-running 5-bit divider.
module xs_clk_rst_seq
    import xs_clk_pkg::*;
#(
    parameter int unsigned LOCK_HOLD = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic pll_locked,
    input  logic ioctl_download,
    input  logic pause,
    output logic core_rst,
    output logic ce_12,
    output logic ce_6,
    output logic ce_3,
    output logic ce_1p5,
    output logic ce_e_rise,
    output logic ce_e_fall,
    output logic ce_q_rise,
    output logic ce_q_fall
);

    localparam int unsigned       HOLD_W    = $clog2(LOCK_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LOCK_HOLD - 1);

    logic              lk;
    seq_state_t        state, state_nxt;
    logic [HOLD_W-1:0] hold_cnt, hold_cnt_nxt;
    logic [DIV_W-1:0]  div, div_nxt;
    ce_vec_t           ce_q, ce_nxt;
    logic              run_stay;

    xs_sync2 u_lock_sync (
        .clk     (clk),
        .rst     (rst),
        .rst_val (1'b0),
        .d       (pll_locked),
        .q       (lk)
    );

    // Next state, hold count, divider and enable decode
    always_comb begin
        state_nxt    = state;
        hold_cnt_nxt = '0;
        unique case (state)
            WAIT: begin
                if (lk && !ioctl_download) state_nxt = HOLD;
            end
            HOLD: begin
                if (!lk || ioctl_download)   state_nxt = WAIT;
                else if (hold_cnt == HOLD_LAST) state_nxt = RUN;
                else                         hold_cnt_nxt = hold_cnt + 1'b1;
            end
            RUN: begin
                if (!lk || ioctl_download) state_nxt = WAIT;
            end
            default: state_nxt = WAIT;
        endcase

        // The divider only advances while staying in RUN, so the first RUN
        // cycle shows div=0 and leaving RUN clears it on the same edge.
        run_stay = (state == RUN) && (state_nxt == RUN);
        div_nxt  = run_stay ? (pause ? div : div + 1'b1) : '0;
        ce_nxt   = (run_stay && !pause) ? ce_decode(div_nxt) : '0;
    end

    // State, counters and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= WAIT;
            hold_cnt <= '0;
            div      <= '0;
            core_rst <= 1'b1;
            ce_q     <= '0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_cnt_nxt;
            div      <= div_nxt;
            core_rst <= (state_nxt != RUN);
            ce_q     <= ce_nxt;
        end
    end

    assign ce_12     = ce_q.ce_12;
    assign ce_6      = ce_q.ce_6;
    assign ce_3      = ce_q.ce_3;
    assign ce_1p5    = ce_q.ce_1p5;
    assign ce_q_rise = ce_q.q_rise;
    assign ce_e_rise = ce_q.e_rise;
    assign ce_q_fall = ce_q.q_fall;
    assign ce_e_fall = ce_q.e_fall;

endmodule

// File: tb/tb_xs_clk_rst_seq.sv
// Scoreboard bench for xs_clk_rst_seq with LOCK_HOLD=16.
// Output vector bit order: {core_rst, ce_12, ce_6, ce_3, ce_1p5,
//                           q_rise, e_rise, q_fall, e_fall}
module tb_xs_clk_rst_seq;

    localparam int unsigned LH = 16;

    logic clk = 1'b0;
    logic rst, pll_locked, ioctl_download, pause;
    logic core_rst, ce_12, ce_6, ce_3, ce_1p5;
    logic ce_e_rise, ce_e_fall, ce_q_rise, ce_q_fall;

    xs_clk_rst_seq #(.LOCK_HOLD(LH)) dut (
        .clk            (clk),
        .rst            (rst),
        .pll_locked     (pll_locked),
        .ioctl_download (ioctl_download),
        .pause          (pause),
        .core_rst       (core_rst),
        .ce_12          (ce_12),
        .ce_6           (ce_6),
        .ce_3           (ce_3),
        .ce_1p5         (ce_1p5),
        .ce_e_rise      (ce_e_rise),
        .ce_e_fall      (ce_e_fall),
        .ce_q_rise      (ce_q_rise),
        .ce_q_fall      (ce_q_fall)
    );

    always #5 clk = ~clk;

    int unsigned edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    localparam int K_VEC = 0;
    localparam int K_CLR = 1;
    localparam int K_CNT = 2;

    typedef struct {
        int unsigned at;
        int          kind;
        int unsigned idx;
        int unsigned expv;
        string       name;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    int unsigned pc[9];

    task automatic push(input int unsigned at, input int kind, input int unsigned idx,
                        input int unsigned expv, input string name);
        exp_t e;
        e.at = at; e.kind = kind; e.idx = idx; e.expv = expv; e.name = name;
        sb.push_back(e);
    endtask

    task automatic pvec(input int unsigned at, input int unsigned v, input string name);
        push(at, K_VEC, 0, v, name);
    endtask

    task automatic to_edge(input int unsigned t);
        while (edge_n < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: accumulate pulses, then resolve every entry due at this edge
    always @(negedge clk) begin
        logic [8:0] outv;
        outv = {core_rst, ce_12, ce_6, ce_3, ce_1p5,
                ce_q_rise, ce_e_rise, ce_q_fall, ce_e_fall};
        for (int i = 0; i < 9; i++) if (outv[i]) pc[i]++;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].at == edge_n) begin
                if (sb[i].kind == K_CLR) begin
                    for (int j = 0; j < 9; j++) pc[j] = 0;
                end else if (sb[i].kind == K_VEC) begin
                    n_cmp++;
                    if (outv != 9'(sb[i].expv)) begin
                        n_err++;
                        $display("FAIL %s @edge %0d: got %h want %h",
                                 sb[i].name, edge_n, outv, 9'(sb[i].expv));
                    end
                end else begin
                    n_cmp++;
                    if (pc[sb[i].idx] != sb[i].expv) begin
                        n_err++;
                        $display("FAIL %s @edge %0d: got %0d want %0d",
                                 sb[i].name, edge_n, pc[sb[i].idx], sb[i].expv);
                    end
                end
                sb.delete(i);
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    int unsigned n, r, t, r2, t2, r3, t3, r4;

    initial begin
        rst = 1'b1; pll_locked = 1'b1; ioctl_download = 1'b0; pause = 1'b0;
        to_edge(3);

        // Reset release with lock already high
        n = edge_n;
        r = n + LH + 3;
        pvec(n,      9'h100, "reset_state");
        pvec(r - 1,  9'h100, "rst_before_release");
        pvec(r,      9'h000, "release_div0");
        pvec(r + 2,  9'h000, "run_div2");
        pvec(r + 3,  9'h080, "first_ce12");
        pvec(r + 31, 9'h0F1, "div31_all");
        pvec(r + 32, 9'h000, "div_wrap0");
        pvec(r + 39, 9'h0C8, "q_rise_div7");
        pvec(r + 47, 9'h0E4, "e_rise_div15");
        pvec(r + 55, 9'h0C2, "q_fall_div23");
        // 256-cycle pulse census over whole divider periods
        push(r + 32, K_CLR, 0, 0, "clr");
        push(r + 288, K_CNT, 8, 0,  "cnt_core_rst");
        push(r + 288, K_CNT, 7, 64, "cnt_ce12");
        push(r + 288, K_CNT, 6, 32, "cnt_ce6");
        push(r + 288, K_CNT, 5, 16, "cnt_ce3");
        push(r + 288, K_CNT, 4, 8,  "cnt_ce1p5");
        push(r + 288, K_CNT, 3, 8,  "cnt_q_rise");
        push(r + 288, K_CNT, 2, 8,  "cnt_e_rise");
        push(r + 288, K_CNT, 1, 8,  "cnt_q_fall");
        push(r + 288, K_CNT, 0, 8,  "cnt_e_fall");
        rst = 1'b0;

        // Lock loss for 5 cycles in RUN
        t  = r + 301;
        r2 = t + 5 + LH + 3;
        pvec(t + 2,  9'h0E4, "pre_loss_div15");
        pvec(t + 3,  9'h100, "lock_loss_rst");
        pvec(r2 - 1, 9'h100, "relock_hold");
        pvec(r2,     9'h000, "relock_div0");
        pvec(r2 + 3, 9'h080, "relock_ce12");
        to_edge(t);
        pll_locked = 1'b0;
        to_edge(t + 5);
        pll_locked = 1'b1;

        // Drop lock, then glitch it during HOLD
        t2 = r2 + 40;
        r3 = t2 + 15 + LH + 3;
        pvec(t2 + 3,  9'h100, "glitch_pre_wait");
        pvec(t2 + 21, 9'h100, "glitch_no_early");
        pvec(r3 - 1,  9'h100, "glitch_hold");
        pvec(r3,      9'h000, "glitch_release");
        to_edge(t2);
        pll_locked = 1'b0;
        to_edge(t2 + 2);
        pll_locked = 1'b1;
        to_edge(t2 + 12);
        pll_locked = 1'b0;
        to_edge(t2 + 15);
        pll_locked = 1'b1;

        // Download pulse of 100 cycles in RUN
        t3 = r3 + 40;
        r4 = t3 + 100 + LH + 1;
        pvec(t3,      9'h000, "pre_dl_div8");
        pvec(t3 + 1,  9'h100, "dl_rst");
        pvec(r4 - 1,  9'h100, "dl_hold");
        pvec(r4,      9'h000, "dl_release");
        to_edge(t3);
        ioctl_download = 1'b1;
        to_edge(t3 + 100);
        ioctl_download = 1'b0;

        // Pause for 10 cycles at div=5, then 3 cycles at div=11
        push(r4 + 5, K_CLR, 0, 0, "clr");
        pvec(r4 + 6,  9'h000, "pause_div5_a");
        pvec(r4 + 15, 9'h000, "pause_div5_b");
        push(r4 + 15, K_CNT, 7, 0, "pause_no_ce12");
        pvec(r4 + 16, 9'h000, "resume_div6");
        pvec(r4 + 17, 9'h0C8, "resume_q_rise");
        pvec(r4 + 21, 9'h080, "div11_ce12");
        pvec(r4 + 22, 9'h000, "pause_div11_a");
        pvec(r4 + 24, 9'h000, "pause_div11_b");
        pvec(r4 + 25, 9'h000, "resume_div12");
        pvec(r4 + 28, 9'h0E4, "resume_e_rise");
        to_edge(r4 + 5);
        pause = 1'b1;
        to_edge(r4 + 15);
        pause = 1'b0;
        to_edge(r4 + 21);
        pause = 1'b1;
        to_edge(r4 + 24);
        pause = 1'b0;

        // Reset together with lock loss mid-RUN
        pvec(r4 + 40, 9'h080, "pre_rst_div27");
        pvec(r4 + 41, 9'h100, "rst_midrun");
        pvec(r4 + 45, 9'h100, "rst_held");
        to_edge(r4 + 40);
        rst = 1'b1;
        pll_locked = 1'b0;
        to_edge(r4 + 47);

        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL sb_drain: got %0d pending want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
